// File: rtl/i2c_package.sv
// Shared types and constants for the I2C transfer sequencer.
package i2c_package;

  // Sequencer states, from request acceptance through completion.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REG,
    WDATA,
    RADDR,
    RDATA,
    STOP,
    DONE
  } seq_state_t;

  // Completion status codes held after a transfer ends.
  localparam logic [1:0] STATUS_OK   = 2'd0;
  localparam logic [1:0] STATUS_NACK = 2'd1;
  localparam logic [1:0] STATUS_AL   = 2'd2;

  // R/W bit appended to the 7-bit slave address.
  localparam logic I2C_DIR_WRITE = 1'b0;
  localparam logic I2C_DIR_READ  = 1'b1;

endpackage

// File: rtl/i2c_xfer_seq.sv
// Register-oriented I2C transfer sequencer: turns one request into a chain
// of byte-controller commands (address, register pointer, data bytes).
module i2c_xfer_seq
  import i2c_package::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rnw,
  input  logic [7:0]       req_reg,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err_nack,
  output logic             err_al,
  output logic             bc_start,
  output logic             bc_stop,
  output logic             bc_read,
  output logic             bc_write,
  output logic             bc_ack_in,
  output logic [7:0]       bc_din,
  input  logic             bc_cmd_ack,
  input  logic             bc_ack_out,
  input  logic [7:0]       bc_dout,
  input  logic             bc_al
);

  seq_state_t       state;
  logic [1:0]       status;
  logic [6:0]       addr_q;
  logic             rnw_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] cnt;
  logic             outstanding;
  logic             last;

  assign outstanding = bc_start | bc_stop | bc_read | bc_write;
  assign last        = (cnt == LEN_W'(1));
  assign err_nack    = (status == STATUS_NACK);
  assign err_al      = (status == STATUS_AL);

  // Main sequencer: one command in flight at a time, outputs all registered.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      status    <= STATUS_OK;
      addr_q    <= '0;
      rnw_q     <= 1'b0;
      reg_q     <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      bc_start  <= 1'b0;
      bc_stop   <= 1'b0;
      bc_read   <= 1'b0;
      bc_write  <= 1'b0;
      bc_ack_in <= 1'b0;
      bc_din    <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;

      if (outstanding && bc_cmd_ack) begin
        bc_start  <= 1'b0;
        bc_stop   <= 1'b0;
        bc_read   <= 1'b0;
        bc_write  <= 1'b0;
        bc_ack_in <= 1'b0;
      end

      if (bc_al && (state inside {ADDR, REG, WDATA, RADDR, RDATA, STOP})) begin
        bc_start  <= 1'b0;
        bc_stop   <= 1'b0;
        bc_read   <= 1'b0;
        bc_write  <= 1'b0;
        bc_ack_in <= 1'b0;
        wr_ready  <= 1'b0;
        status    <= STATUS_AL;
        done      <= 1'b1;
        state     <= DONE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid && req_ready) begin
              addr_q    <= req_addr;
              rnw_q     <= req_rnw;
              reg_q     <= req_reg;
              cnt       <= req_len;
              status    <= STATUS_OK;
              req_ready <= 1'b0;
              bc_start  <= 1'b1;
              bc_write  <= 1'b1;
              bc_ack_in <= 1'b0;
              bc_din    <= {req_addr, I2C_DIR_WRITE};
              state     <= ADDR;
            end
          end
          ADDR: begin
            if (outstanding && bc_cmd_ack) begin
              if (bc_ack_out) begin
                status <= STATUS_NACK;
                state  <= STOP;
              end else begin
                state <= REG;
              end
            end
          end
          REG: begin
            if (!outstanding) begin
              bc_write <= 1'b1;
              bc_stop  <= (cnt == '0);
              bc_din   <= reg_q;
            end else if (bc_cmd_ack) begin
              if (bc_ack_out) begin
                status <= STATUS_NACK;
                state  <= STOP;
              end else if (cnt == '0) begin
                done  <= 1'b1;
                state <= DONE;
              end else if (rnw_q) begin
                state <= RADDR;
              end else begin
                state <= WDATA;
              end
            end
          end
          WDATA: begin
            if (outstanding) begin
              if (bc_cmd_ack) begin
                if (bc_ack_out) begin
                  status <= STATUS_NACK;
                  state  <= STOP;
                end else begin
                  if (cnt != '0) cnt <= cnt - LEN_W'(1);
                  if (last) begin
                    done  <= 1'b1;
                    state <= DONE;
                  end
                end
              end
            end else if (wr_ready) begin
              if (wr_valid) begin
                wr_ready <= 1'b0;
                bc_din   <= wr_data;
                bc_write <= 1'b1;
                bc_stop  <= last;
              end
            end else if (wr_valid) begin
              wr_ready <= 1'b1;
            end
          end
          RADDR: begin
            if (!outstanding) begin
              bc_start <= 1'b1;
              bc_write <= 1'b1;
              bc_din   <= {addr_q, I2C_DIR_READ};
            end else if (bc_cmd_ack) begin
              if (bc_ack_out) begin
                status <= STATUS_NACK;
                state  <= STOP;
              end else begin
                state <= RDATA;
              end
            end
          end
          RDATA: begin
            if (!outstanding) begin
              bc_read   <= 1'b1;
              bc_ack_in <= last;
              bc_stop   <= last;
            end else if (bc_cmd_ack) begin
              rd_valid <= 1'b1;
              rd_data  <= bc_dout;
              if (cnt != '0) cnt <= cnt - LEN_W'(1);
              if (last) begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          STOP: begin
            if (!outstanding) begin
              bc_stop <= 1'b1;
            end else if (bc_cmd_ack) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
          default: begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq with an inline byte-controller responder.
module tb_i2c_xfer_seq;

  logic       clk = 1'b0;
  logic       nReset;
  logic       req_valid, req_ready, req_rnw;
  logic [6:0] req_addr;
  logic [7:0] req_reg;
  logic [3:0] req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done, err_nack, err_al;
  logic       bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0] bc_din;
  logic       bc_cmd_ack, bc_ack_out, bc_al;
  logic [7:0] bc_dout;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  i2c_xfer_seq #(.LEN_W(4)) dut (
    .clk(clk), .nReset(nReset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_reg(req_reg), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err_nack(err_nack), .err_al(err_al),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read), .bc_write(bc_write),
    .bc_ack_in(bc_ack_in), .bc_din(bc_din),
    .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout), .bc_al(bc_al)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [3:0] cmdBits();
    return {bc_start, bc_stop, bc_read, bc_write};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present a request, then scramble the request inputs to prove they were latched.
  task automatic applyStimulus(input string tag, input logic [6:0] addr, input logic rnw,
                               input logic [7:0] regp, input logic [3:0] len);
    checkOutput({tag, ".req_ready"}, req_ready, 1);
    req_addr  = addr;
    req_rnw   = rnw;
    req_reg   = regp;
    req_len   = len;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    req_addr  = 7'h7F;
    req_rnw   = ~rnw;
    req_reg   = 8'hEE;
    req_len   = 4'hF;
    checkOutput({tag, ".latency"}, cmdBits(), 4'b1001);
    checkOutput({tag, ".busy"}, req_ready, 0);
  endtask

  // mode 0: ack normally, 1: arbitration lost (with a cmd_ack that must be ignored), 2: observe only
  task automatic serveCmd(input string tag, input logic [3:0] expBits, input logic [7:0] expDin,
                          input logic chkDin, input logic expAckIn, input int mode,
                          input logic ackOut, input logic [7:0] dout);
    int n = 0;
    while (cmdBits() == 4'b0000 && n < 40) begin
      cyc();
      n++;
    end
    checkOutput({tag, ".issued"}, (n < 40), 1);
    checkOutput({tag, ".bits"}, cmdBits(), expBits);
    if (chkDin) checkOutput({tag, ".din"}, bc_din, expDin);
    checkOutput({tag, ".ack_in"}, bc_ack_in, expAckIn);
    cyc();
    checkOutput({tag, ".hold"}, {cmdBits(), bc_ack_in}, {expBits, expAckIn});
    if (mode != 2) begin
      bc_cmd_ack = 1'b1;
      bc_ack_out = ackOut;
      bc_dout    = dout;
      bc_al      = (mode == 1);
      cyc();
      bc_cmd_ack = 1'b0;
      bc_ack_out = 1'b0;
      bc_al      = 1'b0;
      checkOutput({tag, ".clear"}, cmdBits(), 4'b0000);
    end
  endtask

  task automatic supplyWrite(input string tag, input logic [7:0] data);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = data;
    cyc();
    while (!wr_ready && n < 40) begin
      cyc();
      n++;
    end
    checkOutput({tag, ".wr_ready"}, wr_ready, 1);
    cyc();
    wr_valid = 1'b0;
    checkOutput({tag, ".wr_ready_pulse"}, wr_ready, 0);
  endtask

  task automatic waitDone(input string tag, input logic expNack, input logic expAl);
    int n = 0;
    while (!done && n < 40) begin
      cyc();
      n++;
    end
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".err"}, {err_nack, err_al}, {expNack, expAl});
    cyc();
    checkOutput({tag, ".done_pulse"}, done, 0);
    checkOutput({tag, ".idle_ready"}, req_ready, 1);
    checkOutput({tag, ".err_held"}, {err_nack, err_al}, {expNack, expAl});
    checkOutput({tag, ".no_cmd"}, cmdBits(), 4'b0000);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    nReset = 1'b1;
    req_valid = 0; req_addr = 0; req_rnw = 0; req_reg = 0; req_len = 0;
    wr_valid = 0; wr_data = 0;
    bc_cmd_ack = 0; bc_ack_out = 0; bc_al = 0; bc_dout = 0;
    #1 nReset = 1'b0;
    repeat (3) cyc();
    checkOutput("reset.req_ready", req_ready, 1);
    checkOutput("reset.outs", {cmdBits(), done, err_nack, err_al, rd_valid, wr_ready}, 9'b0);
    nReset = 1'b1;
    cyc();

    // Register write, two data bytes
    applyStimulus("wr2", 7'h50, 1'b0, 8'h10, 4'd2);
    serveCmd("wr2.addr", 4'b1001, 8'hA0, 1, 0, 0, 0, 8'h00);
    serveCmd("wr2.reg",  4'b0001, 8'h10, 1, 0, 0, 0, 8'h00);
    supplyWrite("wr2.d0", 8'hAA);
    serveCmd("wr2.d0",   4'b0001, 8'hAA, 1, 0, 0, 0, 8'h00);
    supplyWrite("wr2.d1", 8'h55);
    serveCmd("wr2.d1",   4'b0101, 8'h55, 1, 0, 0, 0, 8'h00);
    waitDone("wr2", 0, 0);

    // Register read, three data bytes
    applyStimulus("rd3", 7'h50, 1'b1, 8'h00, 4'd3);
    serveCmd("rd3.addr",  4'b1001, 8'hA0, 1, 0, 0, 0, 8'h00);
    serveCmd("rd3.reg",   4'b0001, 8'h00, 1, 0, 0, 0, 8'h00);
    serveCmd("rd3.raddr", 4'b1001, 8'hA1, 1, 0, 0, 0, 8'h00);
    serveCmd("rd3.r0",    4'b0010, 8'h00, 0, 0, 0, 0, 8'h01);
    checkOutput("rd3.r0.data", {rd_valid, rd_data}, {1'b1, 8'h01});
    cyc();
    checkOutput("rd3.r0.pulse", rd_valid, 0);
    serveCmd("rd3.r1",    4'b0010, 8'h00, 0, 0, 0, 0, 8'h02);
    checkOutput("rd3.r1.data", {rd_valid, rd_data}, {1'b1, 8'h02});
    serveCmd("rd3.r2",    4'b0110, 8'h00, 0, 1, 0, 0, 8'h03);
    checkOutput("rd3.r2.data", {rd_valid, rd_data}, {1'b1, 8'h03});
    waitDone("rd3", 0, 0);

    // Write with NACK on the second data byte
    applyStimulus("nak", 7'h50, 1'b0, 8'h20, 4'd3);
    serveCmd("nak.addr", 4'b1001, 8'hA0, 1, 0, 0, 0, 8'h00);
    serveCmd("nak.reg",  4'b0001, 8'h20, 1, 0, 0, 0, 8'h00);
    supplyWrite("nak.d0", 8'h11);
    serveCmd("nak.d0",   4'b0001, 8'h11, 1, 0, 0, 0, 8'h00);
    supplyWrite("nak.d1", 8'h22);
    serveCmd("nak.d1",   4'b0001, 8'h22, 1, 0, 0, 1, 8'h00);
    wr_valid = 1'b1;
    wr_data  = 8'h33;
    serveCmd("nak.stop", 4'b0100, 8'h00, 0, 0, 0, 0, 8'h00);
    checkOutput("nak.no_req3", wr_ready, 0);
    waitDone("nak", 1, 0);
    checkOutput("nak.no_req3_end", wr_ready, 0);
    wr_valid = 1'b0;

    // Read with arbitration lost during the repeated-start address
    applyStimulus("al", 7'h50, 1'b1, 8'h08, 4'd2);
    serveCmd("al.addr",  4'b1001, 8'hA0, 1, 0, 0, 0, 8'h00);
    serveCmd("al.reg",   4'b0001, 8'h08, 1, 0, 0, 0, 8'h00);
    serveCmd("al.raddr", 4'b1001, 8'hA1, 1, 0, 1, 0, 8'h00);
    waitDone("al", 0, 1);

    // Zero-length read becomes a pointer-only write
    applyStimulus("ptr", 7'h3C, 1'b1, 8'h42, 4'd0);
    serveCmd("ptr.addr", 4'b1001, 8'h78, 1, 0, 0, 0, 8'h00);
    serveCmd("ptr.reg",  4'b0101, 8'h42, 1, 0, 0, 0, 8'h00);
    waitDone("ptr", 0, 0);

    // Single-byte write with the data source stalled for 20 cycles
    applyStimulus("stall", 7'h50, 1'b0, 8'h30, 4'd1);
    serveCmd("stall.addr", 4'b1001, 8'hA0, 1, 0, 0, 0, 8'h00);
    serveCmd("stall.reg",  4'b0001, 8'h30, 1, 0, 0, 0, 8'h00);
    bad = 0;
    repeat (20) begin
      cyc();
      if (cmdBits() != 4'b0000 || wr_ready) bad++;
    end
    checkOutput("stall.quiet", bad, 0);
    supplyWrite("stall.d0", 8'h5A);
    serveCmd("stall.d0", 4'b0101, 8'h5A, 1, 0, 0, 0, 8'h00);
    waitDone("stall", 0, 0);

    // Reset asserted while a read byte is outstanding
    applyStimulus("rst", 7'h50, 1'b1, 8'h01, 4'd2);
    serveCmd("rst.addr",  4'b1001, 8'hA0, 1, 0, 0, 0, 8'h00);
    serveCmd("rst.reg",   4'b0001, 8'h01, 1, 0, 0, 0, 8'h00);
    serveCmd("rst.raddr", 4'b1001, 8'hA1, 1, 0, 0, 0, 8'h00);
    serveCmd("rst.r0",    4'b0010, 8'h00, 0, 0, 2, 0, 8'h00);
    nReset = 1'b0;
    #1;
    checkOutput("rst.req_ready", req_ready, 1);
    checkOutput("rst.outs", {cmdBits(), done, err_nack, err_al, rd_valid, wr_ready, bc_ack_in}, 10'b0);
    checkOutput("rst.din", bc_din, 0);
    repeat (2) cyc();
    nReset = 1'b1;
    bad = 0;
    repeat (5) begin
      cyc();
      if (done || cmdBits() != 4'b0000) bad++;
    end
    checkOutput("rst.no_done", bad, 0);
    checkOutput("rst.ready_after", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 4: width of the byte-count field.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port nReset, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid/req_ready, in/out, 1/1: transaction request handshake; accepted when both are high on one edge.
REQ-005 SHALL have port req_addr, input, 7: target slave address.
REQ-006 SHALL have port req_rnw, input, 1: 1 means register read, 0 means register write.
REQ-007 SHALL have port req_reg, input, 8: register pointer byte.
REQ-008 SHALL have port req_len, input, LEN_W: data byte count, range 0..2^LEN_W-1.
REQ-009 SHALL have port wr_valid/wr_ready/wr_data, in/out/in, 1/1/8: write-data stream.
REQ-010 SHALL have port rd_valid/rd_data, out/out, 1/8: read-data stream; no backpressure.
REQ-011 SHALL have port done/err_nack/err_al, out/out/out, 1/1/1: completion pulse and status.
REQ-012 SHALL have port bc_start/bc_stop/bc_read/bc_write, output, 1 each: byte-controller command bits.
REQ-013 SHALL have port bc_ack_in/bc_din, output, 1/8: ACK bit to send and byte to write.
REQ-014 SHALL have port bc_cmd_ack/bc_ack_out/bc_dout/bc_al, input, 1/1/8/1: byte-controller status.

Function
REQ-015 SHALL sequence a write as: START+WRITE(addr,0); WRITE(reg); WRITE(data) len times, with STOP merged into the last WRITE.
REQ-016 SHALL sequence a read as: START+WRITE(addr,0); WRITE(reg); START+WRITE(addr,1); READ len times, then STOP.
REQ-017 SHALL send ack_in=0 on every read byte except the last, which uses ack_in=1 with STOP merged.
REQ-018 SHALL treat len=0 (either direction) as a pointer-only write: the STOP is merged into WRITE(reg).
REQ-019 SHALL use states IDLE, ADDR, REG, WDATA, RADDR, RDATA, STOP, DONE.
REQ-020 SHALL hold each command bit set and bc_din/bc_ack_in stable from issue until the cycle bc_cmd_ack=1.
REQ-021 SHALL clear all command bits in the cycle following bc_cmd_ack, so that at most one command is outstanding.
REQ-022 SHALL drive req_ready=1 only in IDLE.
REQ-023 SHALL register req_addr/req_rnw/req_reg/req_len at acceptance; later changes to these inputs are ignored.
REQ-024 SHALL, in WDATA, drive wr_ready=1 for one cycle when wr_valid=1 and no command is outstanding, latching wr_data into bc_din.
REQ-025 SHALL issue the WRITE command in the cycle after the wr_valid/wr_ready handshake.
REQ-026 SHALL keep all command bits low while wr_valid=0 (stall).
REQ-027 SHALL pulse rd_valid for 1 cycle with rd_data=bc_dout on each READ bc_cmd_ack.
REQ-028 SHALL, on any WRITE bc_cmd_ack with bc_ack_out=1 (NACK), abandon remaining bytes, issue a STOP-only command, then go to DONE with err_nack=1.
REQ-029 SHALL, on bc_al=1 in any state, go directly to DONE with err_al=1 and no STOP; bc_cmd_ack in the same cycle is ignored.
REQ-030 SHALL, in DONE, pulse done for 1 cycle, hold err_nack/err_al valid until the next acceptance, then return to IDLE.
REQ-031 SHALL count remaining bytes with a LEN_W-bit down-counter; "last byte" is count==1, with no wrap below 0.
REQ-032 SHALL set request latency at 1 cycle: acceptance to first command bit asserted.

Reset
REQ-033 SHALL, on nReset=0, immediately set state=IDLE, set all outputs to 0 (except req_ready=1), and clear the counter and latches.
REQ-034 SHALL, on nReset=0 mid-transaction, abandon the transfer with no STOP and no done pulse; recovery is the byte controller's concern.

Structure
REQ-035 SHALL place the sequencer state enum and the status-code constants in i2c_package.
REQ-036 SHALL contain no sub-module; i2c_xfer_seq is instantiated beside the byte controller by the top level.

Verification
REQ-037 Write addr=0x50, reg=0x10, len=2, data 0xAA,0x55, all ACK -> commands START+W(0xA0), W(0x10), W(0xAA), W+STOP(0x55); then done=1, err=0.
REQ-038 Read addr=0x50, reg=0x00, len=3, bc_dout 1,2,3 -> rd_valid ×3 with 1,2,3; ack_in 0,0,1; STOP on the last read; done=1.
REQ-039 Write len=3 with NACK on the 2nd data byte -> STOP-only issued, the 3rd byte is never requested, done=1, err_nack=1.
REQ-040 Read len=2 with bc_al=1 during RADDR -> no STOP, done=1, err_al=1, req_ready=1 next cycle.
REQ-041 Write len=1 with wr_valid held low 20 cycles -> no command bits set during the stall; the transfer then completes normally.
REQ-042 nReset asserted during RDATA -> outputs zero and req_ready=1 immediately; no done pulse.
